// File: rtl/mpu_bus_master.sv
// ============================================================================
//  Module      : mpu_bus_master
//  Description : Bus initiator for the ChronoCube MPU-side interface. Takes
//                single or burst commands from a valid/ready stream, issues
//                fill-style write bursts or read bursts with address
//                auto-increment, and returns read words on a valid/ready
//                response stream.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, reset          system clock, asynchronous active-high reset
//    cmd_valid/ready     command handshake
//    cmd_write           1 = write/fill, 0 = read
//    cmd_addr/data/be    start address, fill data, byte enables
//    cmd_len             burst length minus one (1..256 words)
//    rsp_valid/ready     read response handshake, rsp_data = read word
//    busy                transaction in progress
//    mpu_en/rd/wr/be     MPU bus strobes and byte enables
//    mpu_addr            MPU bus address
//    mpu_data_out/in     MPU write data / read data
// ============================================================================
`default_nettype none

module mpu_bus_master #(
  parameter int READ_WAIT = 1,
  parameter int ADDR_STEP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_addr,
  input  logic [15:0] cmd_data,
  input  logic [1:0]  cmd_be,
  input  logic [7:0]  cmd_len,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        busy,
  output logic        mpu_en,
  output logic        mpu_rd,
  output logic        mpu_wr,
  output logic [1:0]  mpu_be,
  output logic [15:0] mpu_addr,
  output logic [15:0] mpu_data_out,
  input  logic [15:0] mpu_data_in
);

  localparam logic [15:0] c_addr_step = 16'(ADDR_STEP);
  localparam logic [2:0]  c_read_wait = 3'(READ_WAIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_addr, w_addr_nxt;       // address of the word in flight
  logic [7:0]  r_remain, w_remain_nxt;   // words left after the current one
  logic [2:0]  r_wait, w_wait_nxt;       // read strobe cycle counter
  logic [15:0] r_data, w_data_nxt;       // latched fill data
  logic [1:0]  r_be, w_be_nxt;           // latched byte enables

  logic        r_cmd_ready, w_cmd_ready_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_rsp_valid, w_rsp_valid_nxt;
  logic [15:0] r_rsp_data, w_rsp_data_nxt;
  logic        r_mpu_en, w_mpu_en_nxt;
  logic        r_mpu_rd, w_mpu_rd_nxt;
  logic        r_mpu_wr, w_mpu_wr_nxt;
  logic [1:0]  r_mpu_be, w_mpu_be_nxt;
  logic [15:0] r_mpu_addr, w_mpu_addr_nxt;
  logic [15:0] r_mpu_dout, w_mpu_dout_nxt;

  // Every output is registered from the *next* state, so the bus pins in a
  // given cycle always describe the state the FSM is currently in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_addr      <= 16'h0000;
      r_remain    <= 8'h00;
      r_wait      <= 3'd0;
      r_data      <= 16'h0000;
      r_be        <= 2'b00;
      r_cmd_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 16'h0000;
      r_mpu_en    <= 1'b0;
      r_mpu_rd    <= 1'b0;
      r_mpu_wr    <= 1'b0;
      r_mpu_be    <= 2'b00;
      r_mpu_addr  <= 16'h0000;
      r_mpu_dout  <= 16'h0000;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_remain    <= w_remain_nxt;
      r_wait      <= w_wait_nxt;
      r_data      <= w_data_nxt;
      r_be        <= w_be_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_busy      <= w_busy_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_mpu_en    <= w_mpu_en_nxt;
      r_mpu_rd    <= w_mpu_rd_nxt;
      r_mpu_wr    <= w_mpu_wr_nxt;
      r_mpu_be    <= w_mpu_be_nxt;
      r_mpu_addr  <= w_mpu_addr_nxt;
      r_mpu_dout  <= w_mpu_dout_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_remain_nxt   = r_remain;
    w_wait_nxt     = r_wait;
    w_data_nxt     = r_data;
    w_be_nxt       = r_be;
    w_rsp_data_nxt = r_rsp_data;

    case (r_state)
      S_IDLE: begin
        // r_cmd_ready is low in the first cycle after reset release.
        if (cmd_valid && r_cmd_ready) begin
          w_addr_nxt   = cmd_addr;
          w_remain_nxt = cmd_len;
          w_data_nxt   = cmd_data;
          w_be_nxt     = cmd_be;
          w_wait_nxt   = 3'd0;
          w_state_nxt  = cmd_write ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        if (r_remain == 8'h00) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_addr_nxt   = r_addr + c_addr_step;
          w_remain_nxt = r_remain - 8'h01;
        end
      end
      S_READ: begin
        if (r_wait == c_read_wait) begin
          w_rsp_data_nxt = mpu_data_in;
          w_state_nxt    = S_RESP;
        end else begin
          w_wait_nxt = r_wait + 3'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          if (r_remain == 8'h00) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_addr_nxt   = r_addr + c_addr_step;
            w_remain_nxt = r_remain - 8'h01;
            w_wait_nxt   = 3'd0;
            w_state_nxt  = S_READ;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_cmd_ready_nxt = (w_state_nxt == S_IDLE);
    w_busy_nxt      = (w_state_nxt != S_IDLE);
    w_rsp_valid_nxt = (w_state_nxt == S_RESP);
    w_mpu_wr_nxt    = (w_state_nxt == S_WRITE);
    w_mpu_rd_nxt    = (w_state_nxt == S_READ);
    w_mpu_en_nxt    = w_mpu_wr_nxt || w_mpu_rd_nxt;

    // Address, enables and data hold their last value while the bus is idle.
    w_mpu_addr_nxt  = w_mpu_en_nxt ? w_addr_nxt : r_mpu_addr;
    w_mpu_be_nxt    = w_mpu_en_nxt ? w_be_nxt   : r_mpu_be;
    if (w_mpu_wr_nxt) begin
      w_mpu_dout_nxt = w_data_nxt;
    end else if (w_mpu_rd_nxt) begin
      w_mpu_dout_nxt = 16'h0000;
    end else begin
      w_mpu_dout_nxt = r_mpu_dout;
    end
  end

  assign cmd_ready    = r_cmd_ready;
  assign busy         = r_busy;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_data     = r_rsp_data;
  assign mpu_en       = r_mpu_en;
  assign mpu_rd       = r_mpu_rd;
  assign mpu_wr       = r_mpu_wr;
  assign mpu_be       = r_mpu_be;
  assign mpu_addr     = r_mpu_addr;
  assign mpu_data_out = r_mpu_dout;

endmodule

`default_nettype wire

// File: doc/mpu_bus_master.md
# mpu_bus_master

Bus initiator that drives the ChronoCube MPU-side interface (mpu_en/rd/wr/be/addr/data) from a valid/ready command stream. It accepts single or burst transactions and issues cycle-accurate write and read cycles, with address auto-increment. Read data is returned on a valid/ready response stream. It sits between a host bridge (UART/SPI front end or a test CPU) and the ChronoCube top level. Burst writes are fill-style: every word in the burst is written with the same data, which is used for clearing VRAM, tilemap and palette regions.

## Interface
Parameters:
- READ_WAIT, 1, extra cycles the read strobe is held before sampling; covers registered-output block RAMs; legal range 0..7.
- ADDR_STEP, 1, address increment between burst words.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write/fill, 0 = read.
- cmd_addr  in  16  start address, as seen by the MPU bus.
- cmd_data  in  16  write data, used for every word of the burst.
- cmd_be  in  2  byte enables, active high, held for the whole burst.
- cmd_len  in  8  burst length minus one; 0..255 gives 1..256 words.
- rsp_valid  out  1  read word available.
- rsp_ready  in  1  consumer accepts the read word.
- rsp_data  out  16  read word.
- busy  out  1  transaction in progress.
- mpu_en  out  1  bus enable.
- mpu_rd  out  1  read strobe.
- mpu_wr  out  1  write strobe.
- mpu_be  out  2  byte enables.
- mpu_addr  out  16  address.
- mpu_data_out  out  16  write data, toward the device.
- mpu_data_in  in  16  read data, from the device.

## Operation
- All outputs are registered. States: IDLE, WRITE, READ, RESP.
- IDLE
  - cmd_ready=1, all bus strobes 0.
  - On cmd_valid&cmd_ready, latch the command: cur_addr=cmd_addr, remaining=cmd_len.
  - Go to WRITE if cmd_write=1, else READ.
- WRITE
  - Each cycle drives mpu_en=1, mpu_wr=1, mpu_rd=0, mpu_be=cmd_be, mpu_addr=cur_addr, mpu_data_out=cmd_data.
  - If remaining==0, go to IDLE.
  - Otherwise cur_addr+=ADDR_STEP, remaining-=1, and stay in WRITE.
- READ
  - Drives mpu_en=1, mpu_rd=1, mpu_wr=0, mpu_be=cmd_be, mpu_addr=cur_addr, mpu_data_out=0.
  - Held for READ_WAIT+1 cycles.
  - In the last of those cycles, mpu_data_in is sampled into rsp_data; next state is RESP.
- RESP
  - Bus idle (mpu_en=mpu_rd=mpu_wr=0); rsp_valid=1; rsp_data stable until the handshake.
  - On rsp_valid&rsp_ready with remaining==0: go to IDLE.
  - On rsp_valid&rsp_ready with remaining!=0: cur_addr+=ADDR_STEP, remaining-=1, go to READ.
- Address arithmetic is 16-bit modulo; 0xFFFF+1 wraps to 0x0000. There is no wrap flag and no error.
- busy=1 in every state except IDLE.
- mpu_addr, mpu_be and mpu_data_out hold their last value while the bus is idle; only the strobes return to 0.
- No command is accepted while busy. A command presented during a transaction waits (cmd_valid held, cmd_ready=0).

## Timing
- Reset, while asserted and asynchronously:
  - state=IDLE.
  - cmd_ready=0; every other output 0.
- cmd_ready rises on the first clk edge after reset deasserts.
- Reset mid-burst: strobes drop immediately; the remaining words are abandoned; any pending rsp_valid is cleared.
- Command accept edge: cmd_ready drops on the next edge; the first bus cycle is visible in the cycle after acceptance.
- Write burst of N words:
  - Occupies exactly N consecutive cycles with mpu_wr=1.
  - cmd_ready returns 1 in the cycle after the last write strobe.
- Read word latency: READ_WAIT+1 strobe cycles, then rsp_valid in the next cycle.
- Read throughput with rsp_ready tied high: READ_WAIT+2 cycles per word.
- mpu_rd and mpu_wr are never 1 in the same cycle.
- rsp_valid and any bus strobe are never 1 in the same cycle.

## Test plan
- Single write. Command write, addr=0x0200, data=0xBEEF, be=2'b11, len=0.
  - Exactly one cycle shows en=1, wr=1, addr=0x0200, data_out=0xBEEF, be=11.
  - cmd_ready returns to 1 one cycle later.
- Fill with wrap. Command write, addr=0xFFFE, data=0x0000, len=3.
  - Four consecutive write cycles at 0xFFFE, 0xFFFF, 0x0000, 0x0001.
  - busy is high for exactly 4 cycles.
- Read with READ_WAIT=1. Command read, addr=0x0010, len=0; device model returns 0x1234 one cycle after the address.
  - rd is high for 2 cycles; rsp_valid=1 with rsp_data=0x1234 in the 3rd cycle.
- Back-pressure. Read burst, len=2, at 0x0100; rsp_ready low for 5 cycles on the 2nd word.
  - rsp_data is held stable and the bus stays idle during the stall.
  - Addresses issued are 0x0100, 0x0101, 0x0102.
  - Exactly 3 responses are delivered.
- Reset mid-burst. Assert reset during word 2 of a 10-word fill.
  - Strobes drop in the same cycle, without waiting for a clock edge.
  - After release, cmd_ready=1 and a new single read completes normally.
- Command during busy. Present a second command while a 4-word write is active.
  - It is accepted only in the cycle after the 4th write.
  - No bus cycle overlaps the first burst.
